// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and output payload for the fetch controller
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_W = 32;
   localparam int IMEM_DEPTH_DEF = 400;
   typedef enum logic [1:0] {RUN, DRAIN, HALT, FAULT} fetch_state_t;
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } fetch_out_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: imem, redirect and decode-side handshake signals of the fetch controller
interface fetch_ctrl_if;
   import fetch_pkg::*;
   logic [PC_W-1:0] imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic out_valid;
   logic out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0] out_pc;
   logic halted;
   logic fault;
   modport master(
      output imem_addr, out_valid, out_instr, out_pc, halted, fault,
      input imem_rdata, redirect_valid, redirect_pc, out_ready
   );
   modport slave(
      input imem_addr, out_valid, out_instr, out_pc, halted, fault,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: valid/ready output register holding {pc, instr}, with flush and hold
module fetch_out_reg
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       flush,
   input  logic       ready,
   input  fetch_out_t d,
   output logic       valid,
   output fetch_out_t q
);
   // flush beats load so a redirected-away word never reaches decode
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         q <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q <= d;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC, run/drain/halt FSM and output stage for instruction fetch;
// define FETCH_BOUNDS_EN to trap out-of-range redirect targets in a sticky FAULT state.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic rst,
   fetch_ctrl_if.master bus
);
   logic [PC_W-1:0] pc_q;
   fetch_state_t state;
   logic load, redir, bad;
   fetch_out_t d, o;
   assign load = (state == RUN) && (!bus.out_valid || bus.out_ready);
`ifdef FETCH_BOUNDS_EN
   assign redir = bus.redirect_valid && (state != FAULT);
   assign bad = bus.redirect_pc >= PC_W'(IMEM_DEPTH);
   assign bus.fault = state == FAULT;
`else
   assign redir = bus.redirect_valid;
   assign bad = 1'b0;
   assign bus.fault = 1'b0;
`endif
   assign bus.imem_addr = pc_q;
   assign bus.halted = state == HALT;
   assign d = '{pc: pc_q, instr: bus.imem_rdata};
   assign bus.out_pc = o.pc;
   assign bus.out_instr = o.instr;
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
         state <= RUN;
      end else if (redir) begin
         state <= bad ? FAULT : RUN;
         if (!bad) pc_q <= bus.redirect_pc;
      end else if (load) begin
         pc_q <= pc_q + PC_W'(1);
         if (pc_q == PC_W'(IMEM_DEPTH - 1)) state <= DRAIN;
      end else if (state == DRAIN && (!bus.out_valid || bus.out_ready)) begin
         state <= HALT;
      end
   end
   fetch_out_reg u_out (
      .clk(clk),
      .rst(rst),
      .load(load),
      .flush(redir),
      .ready(bus.out_ready),
      .d(d),
      .valid(bus.out_valid),
      .q(o)
   );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized stimulus with a queue-based fetch-stream scoreboard
module tb_fetch_ctrl;
   localparam int DEPTH = 400;
   logic clk = 1'b0;
   logic rst;
   logic [31:0] rom [DEPTH];
   int checks = 0;
   int errors = 0;
   int q[$];
   bit exp_valid = 1'b0;
   bit faulted = 1'b0;
   bit armed = 1'b0;

   always #5 clk = ~clk;

   fetch_ctrl_if bus();
   fetch_ctrl #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.imem_rdata = (bus.imem_addr < DEPTH) ? rom[bus.imem_addr[8:0]]
                                                   : (32'hbad0_0000 ^ bus.imem_addr);

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void fill(int from);
      q.delete();
      for (int p = from; p < DEPTH; p++) q.push_back(p);
   endfunction

   // Reference: the words still owed to decode, in order, from the last reset/redirect to the end of imem.
   always @(negedge clk) begin
      int nxt;
      if (armed) begin
         chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
         if (exp_valid && bus.out_valid && q.size() > 0) begin
            chk("out_pc", bus.out_pc, q[0]);
            chk("out_instr", bus.out_instr, rom[q[0]]);
         end
         chk("halted", 32'(bus.halted), 32'(q.size() == 0 && !faulted));
         chk("fault", 32'(bus.fault), 32'(faulted));
         if (!faulted) begin
            nxt = exp_valid ? (q.size() > 1 ? q[1] : DEPTH) : (q.size() > 0 ? q[0] : DEPTH);
            chk("imem_addr", bus.imem_addr, nxt);
         end
      end
      if (rst) begin
         fill(0);
         exp_valid = 1'b0;
         faulted = 1'b0;
         armed = 1'b1;
      end else if (!armed) begin
      end else if (bus.redirect_valid && !faulted) begin
`ifdef FETCH_BOUNDS_EN
         if (bus.redirect_pc >= DEPTH) begin
            q.delete();
            faulted = 1'b1;
         end else fill(int'(bus.redirect_pc));
`else
         fill(int'(bus.redirect_pc));
`endif
         exp_valid = 1'b0;
      end else if (exp_valid && !bus.out_ready) begin
         exp_valid = 1'b1;
      end else begin
         if (exp_valid && q.size() > 0) void'(q.pop_front());
         exp_valid = !faulted && q.size() > 0;
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic redirect(logic [31:0] t);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = t;
      step(1);
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] tgt;
      for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
      rst = 1'b1;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      step(2);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step(3);
      bus.out_ready = 1'b0;
      step(3);
      bus.out_ready = 1'b1;
      step(5);
      bus.out_ready = 1'b0;
      step(1);
      redirect(100);
      step(2);
      bus.out_ready = 1'b1;
      step(3);
      redirect(397);
      step(6);
      redirect(0);
      step(4);
      redirect(398);
      step(2);
      bus.out_ready = 1'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step(3);
`ifdef FETCH_BOUNDS_EN
      redirect(400);
      step(2);
      redirect(0);
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
`endif
      for (int c = 0; c < 4000; c++) begin
         bus.out_ready = $urandom_range(3) != 0;
         if ($urandom_range(29) == 0) begin
            tgt = ($urandom_range(3) == 0) ? 32'($urandom_range(399, 385)) : 32'($urandom_range(399));
`ifdef FETCH_BOUNDS_EN
            if ($urandom_range(19) == 0) tgt = 32'(400 + $urandom_range(5));
`endif
            redirect(tgt);
         end else if ($urandom_range(299) == 0) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
         end else begin
            step(1);
         end
      end
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
